// File: rtl/avalon_pio_in.sv
// Avalon-MM parallel input port: synchronised inputs, per-bit edge capture with
// write-one-to-clear, interrupt mask and a registered read mux.
module avalon_pio_in #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [31:0]           readdata_q, readdata_d;
  logic                  wr_en;
  logic                  unused_wd;

  assign data  = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect & ~write_n;

  // Bits of writedata above DATA_WIDTH are don't-care for every register.
  assign unused_wd = ^writedata;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = data & ~prev_q;
      1:       edge_det = ~data & prev_q;
      default: edge_det = data ^ prev_q;
    endcase
  end

  always_comb begin
    clr_bits = '0;
    if (wr_en && address == 2'd3) clr_bits = writedata[DATA_WIDTH-1:0];
    // A new edge overrides a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~clr_bits) | edge_det;
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd2) irqmask_d = writedata[DATA_WIDTH-1:0];
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[DATA_WIDTH-1:0] = data;
      2'd2:    readdata_d[DATA_WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q     <= data;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  // Built from flop outputs only, so in_port never reaches irq directly.
  assign irq = (IRQ_MODE == 0) ? |(data & irqmask_q) : |(edgecap_q & irqmask_q);

endmodule
